// File: rtl/axi_req_arbiter_pkg.sv
// Shared definitions for the two-requester AXI-lite request arbiter.
package axi_req_arbiter_pkg;

    // Number of requesters and their fixed indices.
    localparam int NREQ    = 2;
    localparam int REQ_IF  = 0;   // instruction fetch
    localparam int REQ_LSU = 1;   // load/store unit

    // Transaction FSM: at most one AXI-lite transaction is ever outstanding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } state_e;

endpackage

// File: rtl/axi_req_arbiter_rr_arb2.sv
// Two-way round-robin picker. The grant output is combinational and one-hot;
// the last-grant register only moves when a grant is actually taken.
module rr_arb2
    import axi_req_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o
);

    // 1 = the LSU was granted last, so the instruction fetch wins the next tie.
    logic last_q;
    logic last_d;

    // Pick the only requester, or on a tie the one not granted last.
    always_comb begin
        gnt_o  = '0;
        last_d = last_q;
        case (req_i)
            2'b01:   gnt_o[REQ_IF]  = 1'b1;
            2'b10:   gnt_o[REQ_LSU] = 1'b1;
            2'b11: begin
                if (last_q) gnt_o[REQ_IF]  = 1'b1;
                else        gnt_o[REQ_LSU] = 1'b1;
            end
            default: gnt_o = '0;
        endcase
        if (en_i && (|req_i)) begin
            last_d = gnt_o[REQ_LSU];
        end
    end

    // Last-grant register; reset makes the instruction fetch the favoured side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/axi_req_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one AXI-lite
// master port, one transaction at a time. All AXI outputs come from flops.
module axi_req_arbiter
    import axi_req_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    // requester side
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    // AXI-lite read address / data
    output logic [ADDR_W-1:0]        ARADDR,
    output logic                     ARVALID,
    input  logic                     ARREADY,
    input  logic [DATA_W-1:0]        RDATA,
    input  logic                     RVALID,
    output logic                     RREADY,
    // AXI-lite write address / data / response
    output logic [ADDR_W-1:0]        AWADDR,
    output logic                     AWVALID,
    input  logic                     AWREADY,
    output logic [DATA_W-1:0]        WDATA,
    output logic                     WVALID,
    input  logic                     WREADY,
    input  logic                     BVALID,
    output logic                     BREADY
);

    // Unpacked views of the requester buses.
    logic [ADDR_W-1:0] addr_arr  [NREQ];
    logic [DATA_W-1:0] wdata_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    state_e              state_q, state_d;
    logic [NREQ-1:0]     owner_q, owner_d;      // one-hot owner of the open transaction
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;        // drives both ARADDR and AWADDR
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [NREQ-1:0]     arb_gnt;
    logic                arb_en;
    logic                gidx;
    logic                aw_pend;
    logic                w_pend;

    // Grants are only taken in IDLE and never while reset is applied.
    assign arb_en = (state_q == ST_IDLE) && ARESETN;
    assign gidx   = arb_gnt[REQ_LSU];

    rr_arb2 u_rr_arb2 (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .req_i (req_valid),
        .en_i  (arb_en),
        .gnt_o (arb_gnt)
    );

    // A write channel is still pending while its VALID is up and not yet accepted.
    assign aw_pend = awvalid_q && !AWREADY;
    assign w_pend  = wvalid_q  && !WREADY;

    // Next-state and next-output logic; every VALID/READY flop is computed
    // for the state being entered so the outputs line up with the state.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        req_ready   = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_en && (|arb_gnt)) begin
                    req_ready = arb_gnt;
                    owner_d   = arb_gnt;
                    we_d      = req_we[gidx];
                    addr_d    = addr_arr[gidx];
                    wdata_d   = wdata_arr[gidx];
                    if (req_we[gidx]) begin
                        state_d   = ST_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end

            ST_RD_ADDR: begin
                if (ARREADY) begin
                    state_d  = ST_RD_DATA;
                    rready_d = 1'b1;
                end else begin
                    arvalid_d = 1'b1;
                end
            end

            ST_RD_DATA: begin
                if (RVALID) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = owner_q;
                    rsp_rdata_d = we_q ? '0 : RDATA;
                end else begin
                    rready_d = 1'b1;
                end
            end

            ST_WR_REQ: begin
                awvalid_d = aw_pend;
                wvalid_d  = w_pend;
                if (!aw_pend && !w_pend) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end
            end

            ST_WR_RESP: begin
                if (BVALID) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = owner_q;
                    rsp_rdata_d = '0;
                end else begin
                    bready_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any open transaction.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign ARADDR    = addr_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;
    assign AWADDR    = addr_q;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/axi_req_arbiter.md
AXI_REQ_ARBITER -- requirements
Module: axi_req_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of requester and AXI-lite address buses.
REQ-002 Parameter DATA_W, default 32, data width of requester and AXI-lite data buses.
REQ-003 ACLK  in  1  single clock; all state updates on rising edge.
REQ-004 ARESETN  in  1  reset, asynchronous and active-low.
REQ-005 req_valid  in  2  per-requester request; bit0 = instruction fetch, bit1 = load/store.
REQ-006 req_we  in  2  per-requester write-enable; 1 = write, 0 = read.
REQ-007 req_addr  in  2*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
REQ-008 req_wdata  in  2*DATA_W  packed write data, same packing.
REQ-009 req_ready  out  2  one-hot, one-cycle pulse; request accepted.
REQ-010 rsp_valid  out  2  one-hot, one-cycle pulse; transaction complete.
REQ-011 rsp_rdata  out  DATA_W  read data of the last completed read; 0 after a write.
REQ-012 ARADDR/ARVALID out, ARREADY in: AXI-lite read address channel, ADDR_W/1/1.
REQ-013 RDATA/RVALID in, RREADY out: AXI-lite read data channel, DATA_W/1/1.
REQ-014 AWADDR/AWVALID out, AWREADY in: AXI-lite write address channel, ADDR_W/1/1.
REQ-015 WDATA/WVALID out, WREADY in: AXI-lite write data channel, DATA_W/1/1.
REQ-016 BVALID in, BREADY out: AXI-lite write response channel, 1/1.

Function
REQ-017 FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP; one transaction outstanding at most.
REQ-018 IDLE with any req_valid: grant one requester, latch its we/addr/wdata, pulse req_ready[g] in that cycle, go to RD_ADDR (we=0) or WR_REQ (we=1).
REQ-019 Arbitration: one requester valid -> that one; both valid -> requester not granted last (round-robin); the last-grant pointer updates only on a grant.
REQ-020 req_ready is asserted only in IDLE; requesters hold req_valid/we/addr/wdata stable until req_ready.
REQ-021 RD_ADDR: ARVALID=1, ARADDR=latched addr; on ARVALID&&ARREADY go to RD_DATA; ARVALID stays high until the handshake.
REQ-022 RD_DATA: RREADY=1; on RVALID capture RDATA into rsp_rdata, pulse rsp_valid[g] in the next cycle, go to IDLE.
REQ-023 WR_REQ: AWVALID and WVALID both rise on entry; each drops independently after its own handshake; after both handshakes (same or different cycles) go to WR_RESP.
REQ-024 WR_RESP: BREADY=1; on BVALID pulse rsp_valid[g] in the next cycle, clear rsp_rdata to 0, go to IDLE.
REQ-025 Minimum latency with slave ready on every channel: read = 3 cycles and write = 3 cycles, measured from the req_ready cycle to the rsp_valid cycle.
REQ-026 A new grant is legal in the same cycle that rsp_valid pulses, because the FSM is already in IDLE.
REQ-027 All AXI outputs are registered; RREADY and BREADY are high only in their states; a VALID output never deasserts before its handshake.
REQ-028 rsp_rdata holds its value between responses.

Reset
REQ-029 ARESETN low: state=IDLE, the grant pointer favours requester 0, and all outputs, rsp_rdata and latched addr/data are 0.
REQ-030 Reset mid-transaction abandons the transaction; no rsp_valid is issued for it.

Structure
REQ-031 Shared package/header: FSM state encodings, NREQ=2 and the requester index constants (IF=0, LSU=1).
REQ-032 One sub-module, rr_arb2: a 2-way round-robin picker with a last-grant register, which outputs the one-hot grant.

Verification
REQ-033 Single read: req_valid=01, addr=0x8000_0000, slave ARREADY=1 and RVALID=1 with RDATA=0xDEADBEEF -> ARADDR=0x8000_0000; rsp_valid=01 and rsp_rdata=0xDEADBEEF 3 cycles after req_ready.
REQ-034 Contention: req_valid=11 held, both reads -> grants alternate 01,10,01,10; no requester is granted twice in a row.
REQ-035 Write with split handshake: LSU write addr=0x1000, wdata=0x55AA; AWREADY one cycle later than WREADY -> AWVALID and WVALID each drop on their own handshake; BREADY rises only after both; rsp_valid=10 and rsp_rdata=0.
REQ-036 Stalled slave: ARREADY held low for 5 cycles -> ARVALID and ARADDR stay stable; req_ready does not pulse for the waiting requester.
REQ-037 Reset in RD_DATA: ARESETN low for 1 cycle -> all outputs are 0 and state is IDLE; no rsp_valid follows; the next req_valid=10 is granted.
